// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS32 execute stage: ALU, HI/LO forwarding, iterative divider.
// Revision : 1.0
// ============================================================================
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    input  logic [5:0]  stall,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam int            CW         = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] c_cnt_last = CW'(DIV_CYCLES - 1);

    localparam logic [7:0] c_op_and  = 8'b0010_0100;
    localparam logic [7:0] c_op_or   = 8'b0010_0101;
    localparam logic [7:0] c_op_xor  = 8'b0010_0110;
    localparam logic [7:0] c_op_nor  = 8'b0010_0111;
    localparam logic [7:0] c_op_add  = 8'b0010_0000;
    localparam logic [7:0] c_op_addu = 8'b0010_0001;
    localparam logic [7:0] c_op_sub  = 8'b0010_0010;
    localparam logic [7:0] c_op_subu = 8'b0010_0011;
    localparam logic [7:0] c_op_slt  = 8'b0010_1010;
    localparam logic [7:0] c_op_sltu = 8'b0010_1011;
    localparam logic [7:0] c_op_mfhi = 8'b0001_0000;
    localparam logic [7:0] c_op_mthi = 8'b0001_0001;
    localparam logic [7:0] c_op_mflo = 8'b0001_0010;
    localparam logic [7:0] c_op_mtlo = 8'b0001_0011;
    localparam logic [7:0] c_op_div  = 8'b0001_1010;
    localparam logic [7:0] c_op_divu = 8'b0001_1011;

    localparam logic [2:0] c_sel_logic = 3'b001;
    localparam logic [2:0] c_sel_move  = 3'b011;
    localparam logic [2:0] c_sel_arith = 3'b100;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_zero = 2'd1;
    localparam logic [1:0] c_st_busy = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rem;
    logic [31:0]   r_quo;
    logic [31:0]   r_dvs;
    logic          r_q_neg;
    logic          r_r_neg;

    logic          w_is_div;
    logic          w_signed_div;
    logic [31:0]   w_abs1;
    logic [31:0]   w_abs2;
    logic [32:0]   w_shift;
    logic [32:0]   w_diff;
    logic [31:0]   w_hi_fwd;
    logic [31:0]   w_lo_fwd;
    logic [31:0]   w_logic;
    logic [31:0]   w_arith;
    logic [31:0]   w_move;
    logic          w_unused;

    assign w_is_div     = (aluop_i == c_op_div) || (aluop_i == c_op_divu);
    assign w_signed_div = (aluop_i == c_op_div);
    assign w_abs1       = src1_i[31] ? -src1_i : src1_i;
    assign w_abs2       = src2_i[31] ? -src2_i : src2_i;
    assign w_unused     = ^{stall[5:4], stall[2:0]};

    // Partial remainder stays below the divisor, so the shifted value fits in 33 bits.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    assign w_hi_fwd = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
    assign w_lo_fwd = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

    always_comb begin
        w_logic = '0;
        case (aluop_i)
            c_op_and: w_logic = src1_i & src2_i;
            c_op_or:  w_logic = src1_i | src2_i;
            c_op_xor: w_logic = src1_i ^ src2_i;
            c_op_nor: w_logic = ~(src1_i | src2_i);
            default:  w_logic = '0;
        endcase
    end

    always_comb begin
        w_arith = '0;
        case (aluop_i)
            c_op_add, c_op_addu: w_arith = src1_i + src2_i;
            c_op_sub, c_op_subu: w_arith = src1_i - src2_i;
            c_op_slt:            w_arith = {31'd0, $signed(src1_i) < $signed(src2_i)};
            c_op_sltu:           w_arith = {31'd0, src1_i < src2_i};
            default:             w_arith = '0;
        endcase
    end

    always_comb begin
        w_move = '0;
        case (aluop_i)
            c_op_mfhi: w_move = w_hi_fwd;
            c_op_mflo: w_move = w_lo_fwd;
            default:   w_move = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_is_div) w_state_nxt = (src2_i == '0) ? c_st_zero : c_st_busy;
            c_st_zero: w_state_nxt = c_st_done;
            c_st_busy: if (r_cnt == c_cnt_last) w_state_nxt = c_st_done;
            c_st_done: if (!stall[3]) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_is_div) begin
                        r_cnt <= '0;
                        // Divide-by-zero result is settled here; DIV_ZERO only spends the cycle.
                        if (src2_i == '0) begin
                            r_quo   <= '1;
                            r_rem   <= src1_i;
                            r_dvs   <= '0;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_signed_div ? w_abs1 : src1_i;
                            r_dvs   <= w_signed_div ? w_abs2 : src2_i;
                            r_q_neg <= w_signed_div & (src1_i[31] ^ src2_i[31]);
                            r_r_neg <= w_signed_div & src1_i[31];
                        end
                    end
                end
                c_st_busy: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (!w_diff[32]) begin
                        r_rem <= w_diff[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o   = wd_i;
            wreg_o = wreg_i;
            case (alusel_i)
                c_sel_logic: wdata_o = w_logic;
                c_sel_arith: wdata_o = w_arith;
                c_sel_move:  wdata_o = w_move;
                default:     wdata_o = '0;
            endcase
            if (r_state == c_st_done) begin
                whilo_o = 1'b1;
                lo_o    = r_q_neg ? -r_quo : r_quo;
                hi_o    = r_r_neg ? -r_rem : r_rem;
            end else if (aluop_i == c_op_mthi) begin
                whilo_o = 1'b1;
                hi_o    = src1_i;
                lo_o    = w_lo_fwd;
            end else if (aluop_i == c_op_mtlo) begin
                whilo_o = 1'b1;
                hi_o    = w_hi_fwd;
                lo_o    = src1_i;
            end
            stallreq_o = ((r_state == c_st_idle) && w_is_div) ||
                         (r_state == c_st_busy) || (r_state == c_st_zero);
        end
    end

endmodule
`default_nettype wire
